// File: rtl/btn_event_pkg.sv
// Shared types, width helper and default time-base constants for the
// button event controller.
package btn_event_pkg;

  // Default tick constants: 1 ms ticks at 50 MHz.
  localparam int N_BTN_DEF      = 4;
  localparam int TICK_DIV_DEF   = 50000;
  localparam int DEB_TICKS_DEF  = 20;
  localparam int LONG_TICKS_DEF = 1000;
  localparam int REP_TICKS_DEF  = 200;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM_DN    = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    ARM_UP    = 3'd4
  } btn_state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_fsm.sv
// One button: debounce / hold / repeat FSM with registered level and pulses.
// s is the synchronised, polarity-corrected pressed level; tick is the shared
// time-base strobe.
module btn_fsm
  import btn_event_pkg::*;
#(
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int REP_TICKS  = REP_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng,
  output logic rep
);

  localparam int DW = ctr_width(DEB_TICKS - 1);
  localparam int HW = ctr_width(LONG_TICKS - 1);
  localparam int RW = ctr_width(REP_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_TICKS - 1);

  btn_state_t    state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic          from_long;   // ARM_UP origin: 1 = LONG_HELD, 0 = HELD

  // State, counters and registered outputs. Pin level checks come before the
  // tick so a level change always wins; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      rcnt      <= '0;
      from_long <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      lng       <= 1'b0;
      rep       <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
      rep   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARM_DN;
            dcnt  <= '0;
          end
        end
        ARM_DN: begin
          if (!s) state <= IDLE;
          else if (tick) begin
            if (dcnt == DEB_LAST) begin
              state <= HELD;
              press <= 1'b1;
              level <= 1'b1;
              hcnt  <= '0;
            end else dcnt <= dcnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state     <= ARM_UP;
            dcnt      <= '0;
            from_long <= 1'b0;
          end else if (tick) begin
            if (hcnt == LONG_LAST) begin
              state <= LONG_HELD;
              lng   <= 1'b1;
              rcnt  <= '0;
            end else hcnt <= hcnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (!s) begin
            state     <= ARM_UP;
            dcnt      <= '0;
            from_long <= 1'b1;
          end else if (tick) begin
            if (rcnt == REP_LAST) begin
              rep  <= 1'b1;
              rcnt <= '0;
            end else rcnt <= rcnt + 1'b1;
          end
        end
        ARM_UP: begin
          // hcnt/rcnt stay frozen here so a short glitch resumes cleanly.
          if (s) state <= from_long ? LONG_HELD : HELD;
          else if (tick) begin
            if (dcnt == DEB_LAST) begin
              state <= IDLE;
              rel   <= 1'b1;
              level <= 1'b0;
            end else dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-button front end: two-flop synchroniser, polarity fix, shared tick
// generator and one btn_fsm per button.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int REP_TICKS  = REP_TICKS_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_event
);

  localparam int TW = ctr_width(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // Idle pin level; sync flops reset here so reset release shows no press.
  localparam logic [N_BTN-1:0] PIN_IDLE = {N_BTN{ACTIVE_LOW != 0}};

  logic [N_BTN-1:0] sync1, sync2, s;
  logic [TW-1:0]    tcnt;
  logic             tick;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ PIN_IDLE;

  // Free-running time-base; tick marks the last count before wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  assign tick = (tcnt == TICK_LAST);

  btn_fsm #(
    .DEB_TICKS (DEB_TICKS),
    .LONG_TICKS(LONG_TICKS),
    .REP_TICKS (REP_TICKS)
  ) u_fsm [N_BTN-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (s),
    .tick (tick),
    .level(btn_level),
    .press(press_pulse),
    .rel  (release_pulse),
    .lng  (long_pulse),
    .rep  (repeat_pulse)
  );

  assign any_event = |{press_pulse, release_pulse, long_pulse, repeat_pulse};

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: an active-high and an active-low instance share
// clock and reset. Expected pulses (instance, cycle, kind, button) are queued
// when pins are driven; a negedge monitor matches every observed pulse.
module tb_btn_event_ctrl;

  localparam int TD = 4, DEB = 3, LONG = 10, REP = 4;
  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'h0, btn_al = 4'hF;
  logic [3:0] lvl0, pr0, rl0, lg0, rp0, lvl1, pr1, rl1, lg1, rp1;
  logic       ae0, ae1;

  btn_event_ctrl #(.N_BTN(4), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                   .REP_TICKS(REP), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn), .btn_level(lvl0), .press_pulse(pr0),
    .release_pulse(rl0), .long_pulse(lg0), .repeat_pulse(rp0), .any_event(ae0));

  btn_event_ctrl #(.N_BTN(4), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                   .REP_TICKS(REP), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_al), .btn_level(lvl1), .press_pulse(pr1),
    .release_pulse(rl1), .long_pulse(lg1), .repeat_pulse(rp1), .any_event(ae1));

  always #5 clk = ~clk;

  // Edge number since reset release; ticks fall on edges that are multiples of TD.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { int d; int c; int k; int b; } ev_t;
  ev_t q[$];

  logic [3:0] pv [2][4];
  assign pv[0][0] = pr0; assign pv[0][1] = rl0; assign pv[0][2] = lg0; assign pv[0][3] = rp0;
  assign pv[1][0] = pr1; assign pv[1][1] = rl1; assign pv[1][2] = lg1; assign pv[1][3] = rp1;

  int hit;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 4; k++)
          for (int b = 0; b < 4; b++)
            if (pv[d][k][b]) begin
              hit = -1;
              for (int i = 0; i < q.size(); i++)
                if (q[i].d == d && q[i].k == k && q[i].b == b && q[i].c == cyc) hit = i;
              total++;
              if (hit < 0) begin
                bad++;
                $display("FAIL unexpected_pulse dut=%0d kind=%0d btn=%0d cyc=%0d got=1 want=0",
                         d, k, b, cyc);
              end else q.delete(hit);
            end
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].c < cyc) begin
          total++; bad++;
          $display("FAIL missed_pulse dut=%0d kind=%0d btn=%0d want_cyc=%0d got=0 want=1",
                   q[i].d, q[i].k, q[i].b, q[i].c);
          q.delete(i);
        end
    end
  end

  // Accept/release edge for a pin change driven just after edge p.
  function automatic int acc(input int p);
    int t0;
    t0 = p + 3;
    return ((t0 / TD) + 1) * TD + (DEB - 1) * TD;
  endfunction

  task automatic push(input int d, input int c, input int k, input int b);
    ev_t e;
    e.d = d; e.c = c; e.k = k; e.b = b;
    q.push_back(e);
  endtask

  // Expected events for a clean press at p held until r.
  task automatic sched(input int d, input int b, input int p, input int r);
    int a, l;
    a = acc(p);
    push(d, a, K_PRESS, b);
    l = a + TD * LONG;
    if (l <= r + 2) begin
      push(d, l, K_LONG, b);
      for (int e = l + TD * REP; e <= r + 2; e += TD * REP) push(d, e, K_REP, b);
    end
    push(d, acc(r), K_REL, b);
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 4'h0; btn_al = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({lvl0, pr0, rl0, lg0, rp0, ae0, lvl1, pr1, rl1, lg1, rp1, ae1} !== 42'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
                      {lvl0, pr0, rl0, lg0, rp0, ae0, lvl1, pr1, rl1, lg1, rp1, ae1});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if ({lvl0, lvl1, ae0, ae1} !== 10'h0) begin
      bad++; $display("FAIL post_reset_idle got=%h want=0", {lvl0, lvl1, ae0, ae1});
    end
  endtask

  task automatic test_clean_press();
    int p, r;
    @(negedge clk);
    p = cyc; r = p + 80;
    btn[0] = 1'b1;
    sched(0, 0, p, r);
    at_neg(acc(p) + 1);
    total++;
    if (lvl0 !== 4'b0001) begin bad++; $display("FAIL clean_level_hi got=%b want=0001", lvl0); end
    at_neg(r);
    btn[0] = 1'b0;
    at_neg(acc(r) + 1);
    total++;
    if (lvl0 !== 4'b0000) begin bad++; $display("FAIL clean_level_lo got=%b want=0000", lvl0); end
    drain();
  endtask

  task automatic test_bounce();
    int p, r;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      btn[0] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    total++;
    if (lvl0 !== 4'b0000) begin bad++; $display("FAIL bounce_level got=%b want=0000", lvl0); end
    p = cyc; r = p + 24;
    btn[0] = 1'b1;
    sched(0, 0, p, r);
    at_neg(r);
    btn[0] = 1'b0;
    drain();
  endtask

  task automatic test_long_repeat();
    int p, r;
    @(negedge clk);
    p = cyc; r = p + 30 * TD;
    btn[1] = 1'b1;
    sched(0, 1, p, r);
    at_neg(acc(p) + TD * LONG + 1);
    total++;
    if (lvl0 !== 4'b0010) begin bad++; $display("FAIL long_level got=%b want=0010", lvl0); end
    at_neg(r);
    btn[1] = 1'b0;
    drain();
    total++;
    if (lvl0 !== 4'b0000) begin bad++; $display("FAIL long_released got=%b want=0000", lvl0); end
  endtask

  task automatic test_glitch();
    int p, a, g, fz, l, r;
    @(negedge clk);
    p = cyc;
    btn[2] = 1'b1;
    a = acc(p);
    push(0, a, K_PRESS, 2);
    at_neg(a + 12);
    g = cyc;
    btn[2] = 1'b0;
    at_neg(g + 4);
    btn[2] = 1'b1;
    // Ticks seen while in ARM_UP (or lost to the level change) do not advance hcnt.
    fz = 0;
    for (int e = g + 3; e <= g + 7; e++) if (e % TD == 0) fz++;
    l = a + TD * (LONG + fz);
    push(0, l, K_LONG, 2);
    at_neg(g + 9);
    total++;
    if (lvl0 !== 4'b0100) begin bad++; $display("FAIL glitch_level got=%b want=0100", lvl0); end
    at_neg(l + 1);
    r = cyc;
    btn[2] = 1'b0;
    push(0, acc(r), K_REL, 2);
    drain();
  endtask

  task automatic test_simultaneous();
    int p, r;
    @(negedge clk);
    p = cyc; r = p + 30;
    btn = 4'b1001;
    sched(0, 0, p, r);
    sched(0, 3, p, r);
    at_neg(acc(p));
    total++;
    if (pr0 !== 4'b1001) begin bad++; $display("FAIL simul_press got=%b want=1001", pr0); end
    total++;
    if (ae0 !== 1'b1) begin bad++; $display("FAIL simul_any_hi got=%b want=1", ae0); end
    @(negedge clk);
    total++;
    if (ae0 !== 1'b0) begin bad++; $display("FAIL simul_any_lo got=%b want=0", ae0); end
    at_neg(r);
    btn = 4'b0000;
    drain();
  endtask

  task automatic test_active_low_reset();
    int p, a, l;
    @(negedge clk);
    p = cyc;
    btn_al[0] = 1'b0;
    a = acc(p);
    l = a + TD * LONG;
    push(1, a, K_PRESS, 0);
    push(1, l, K_LONG, 0);
    at_neg(a + 1);
    total++;
    if (lvl1 !== 4'b0001) begin bad++; $display("FAIL al_level got=%b want=0001", lvl1); end
    at_neg(l + 2);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({lvl1, pr1, rl1, lg1, rp1, ae1} !== 21'h0) begin
      bad++; $display("FAIL al_async_reset got=%h want=0", {lvl1, pr1, rl1, lg1, rp1, ae1});
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL al_pending got=%0d want=0", q.size()); end
    btn_al = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    total++;
    if ({lvl1, lvl0} !== 8'h0) begin bad++; $display("FAIL al_after_reset got=%h want=0", {lvl1, lvl0}); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_glitch();
    test_simultaneous();
    test_active_low_reset();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
